gaussian_frame_scheduler: RTL and testbench

Frame/line timing scheduler that feeds the 5x5 Gaussian filter pipeline from a valid/ready pixel source, such as a frame-buffer reader. It pulls exactly IMG_HDISP x IMG_VDISP pixels per frame and emits them as per_img_vsync/per_img_href/per_img_gray. It inserts horizontal blanking, vsync pre/post guard intervals and an inter-frame gap, so the downstream line buffers and the 5-cycle arithmetic pipeline drain between lines and frames. It also reports frame completion, frame count and source underrun.

---
 rtl/gaussian_frame_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_gaussian_frame_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_frame_scheduler.sv
`default_nettype none
// ============================================================================
// gaussian_frame_scheduler : frame/line timing for the 5x5 Gaussian filter
// Rev 1.0
// ============================================================================
module gaussian_frame_scheduler #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [15:0] H_BLANK   = 16'd160,
  parameter logic [15:0] V_PRE     = 16'd16,
  parameter logic [15:0] V_POST    = 16'd16,
  parameter logic [15:0] F_GAP     = 16'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        per_img_vsync,
  output logic        per_img_href,
  output logic [7:0]  per_img_gray,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VPRE  = 3'd1,
    S_LINE  = 3'd2,
    S_HBLK  = 3'd3,
    S_VPOST = 3'd4,
    S_FGAP  = 3'd5
  } state_t;

  localparam logic [15:0] c_H_LAST     = {5'd0, IMG_HDISP} - 16'd1;
  localparam logic [10:0] c_V_LAST     = IMG_VDISP - 11'd1;
  localparam logic [15:0] c_VPRE_LAST  = V_PRE - 16'd1;
  localparam logic [15:0] c_HBLK_LAST  = H_BLANK - 16'd1;
  localparam logic [15:0] c_VPOST_LAST = V_POST - 16'd1;
  localparam logic [15:0] c_FGAP_LAST  = F_GAP - 16'd1;

  state_t      r_state;
  logic [15:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [15:0] r_g_cnt;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_gray;
  logic        r_busy;
  logic        r_done_d;
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;
  logic        r_underrun;

  state_t w_nxt;
  state_t w_vpre_entry;
  state_t w_after_fgap;
  state_t w_fgap_entry;
  state_t w_vpost_entry;
  logic   w_seg_end;
  logic   w_line_adv;
  logic   w_last_line_done;
  logic   w_frame_end;
  logic   w_v_last;

  // Zero-length segments are folded into the entry decode so they take no cycles.
  always_comb begin
    w_vpre_entry     = (V_PRE == 16'd0) ? S_LINE : S_VPRE;
    w_after_fgap     = en ? w_vpre_entry : S_IDLE;
    w_fgap_entry     = (F_GAP == 16'd0) ? w_after_fgap : S_FGAP;
    w_vpost_entry    = (V_POST == 16'd0) ? w_fgap_entry : S_VPOST;
    w_v_last         = (r_v_cnt == c_V_LAST);
    w_nxt            = r_state;
    w_seg_end        = 1'b0;
    w_line_adv       = 1'b0;
    w_last_line_done = 1'b0;
    w_frame_end      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_seg_end = 1'b1;
          w_nxt     = w_vpre_entry;
        end
      end
      S_VPRE: begin
        if (r_g_cnt == c_VPRE_LAST) begin
          w_seg_end = 1'b1;
          w_nxt     = S_LINE;
        end
      end
      S_LINE: begin
        if (r_h_cnt == c_H_LAST) begin
          w_seg_end = 1'b1;
          if (H_BLANK != 16'd0) begin
            w_nxt = S_HBLK;
          end else if (w_v_last) begin
            w_nxt            = w_vpost_entry;
            w_last_line_done = 1'b1;
            w_frame_end      = (V_POST == 16'd0);
          end else begin
            w_nxt      = S_LINE;
            w_line_adv = 1'b1;
          end
        end
      end
      S_HBLK: begin
        if (r_g_cnt == c_HBLK_LAST) begin
          w_seg_end = 1'b1;
          if (w_v_last) begin
            w_nxt            = w_vpost_entry;
            w_last_line_done = 1'b1;
            w_frame_end      = (V_POST == 16'd0);
          end else begin
            w_nxt      = S_LINE;
            w_line_adv = 1'b1;
          end
        end
      end
      S_VPOST: begin
        if (r_g_cnt == c_VPOST_LAST) begin
          w_seg_end   = 1'b1;
          w_nxt       = w_fgap_entry;
          w_frame_end = 1'b1;
        end
      end
      S_FGAP: begin
        if (r_g_cnt == c_FGAP_LAST) begin
          w_seg_end = 1'b1;
          w_nxt     = w_after_fgap;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // frame_done is delayed one extra cycle so it lines up with the vsync fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_h_cnt      <= 16'd0;
      r_v_cnt      <= 11'd0;
      r_g_cnt      <= 16'd0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_gray       <= 8'd0;
      r_busy       <= 1'b0;
      r_done_d     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_underrun   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_h_cnt <= (r_state == S_LINE && !w_seg_end) ? r_h_cnt + 16'd1 : 16'd0;
      if (w_seg_end || r_state == S_IDLE || r_state == S_LINE) begin
        r_g_cnt <= 16'd0;
      end else begin
        r_g_cnt <= r_g_cnt + 16'd1;
      end
      if (w_line_adv) begin
        r_v_cnt <= r_v_cnt + 11'd1;
      end else if (w_last_line_done) begin
        r_v_cnt <= 11'd0;
      end
      r_vsync      <= (r_state == S_VPRE) || (r_state == S_LINE) ||
                      (r_state == S_HBLK) || (r_state == S_VPOST);
      r_href       <= (r_state == S_LINE);
      r_gray       <= (r_state == S_LINE && s_valid) ? s_data : 8'd0;
      r_busy       <= (w_nxt != S_IDLE);
      r_done_d     <= w_frame_end;
      r_frame_done <= r_done_d;
      if (r_done_d) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (r_state == S_LINE && !s_valid) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign s_ready       = (r_state == S_LINE);
  assign per_img_vsync = r_vsync;
  assign per_img_href  = r_href;
  assign per_img_gray  = r_gray;
  assign frame_busy    = r_busy;
  assign frame_done    = r_frame_done;
  assign frame_cnt     = r_frame_cnt;
  assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_frame_scheduler.sv
`default_nettype none
// Directed bench for gaussian_frame_scheduler with an 8x4 frame geometry.
module tb_gaussian_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        per_img_vsync;
  logic        per_img_href;
  logic [7:0]  per_img_gray;
  logic        frame_busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        underrun;

  gaussian_frame_scheduler #(
    .IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(16'd4),
    .V_PRE(16'd3), .V_POST(16'd5), .F_GAP(16'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .per_img_vsync(per_img_vsync), .per_img_href(per_img_href),
    .per_img_gray(per_img_gray), .frame_busy(frame_busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Pixel source: ramp data, optional single dropped slot.
  int   pix = 0;
  int   slot_cnt = 0;
  int   n_acc = 0;
  logic drop_en = 1'b0;
  int   drop_idx = 0;
  assign s_valid = !(drop_en && slot_cnt == drop_idx);
  assign s_data  = pix[7:0];

  always @(posedge clk) begin
    if (s_ready) begin
      slot_cnt <= slot_cnt + 1;
      if (s_valid) begin
        n_acc <= n_acc + 1;
        pix   <= pix + 1;
      end
    end
  end

  int n_vs_hi, n_done, n_done_bad, cur_run, cur_hgap, cur_gap;
  bit prev_href, prev_vs, seen_line, seen_frame;
  int run_q[$], hgap_q[$], gap_q[$], gray_q[$], done_cnt_q[$], acc_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (per_img_vsync) n_vs_hi++;
      if (per_img_href) begin
        if (!prev_href && seen_line) hgap_q.push_back(cur_hgap);
        gray_q.push_back(int'(per_img_gray));
        cur_run++;
      end else begin
        if (prev_href) begin
          run_q.push_back(cur_run);
          cur_run   = 0;
          cur_hgap  = 0;
          seen_line = 1'b1;
        end
        if (seen_line && per_img_vsync) cur_hgap++;
      end
      if (!per_img_vsync) begin
        seen_line = 1'b0;
        if (prev_vs) begin
          cur_gap    = 0;
          seen_frame = 1'b1;
        end
        cur_gap++;
      end else if (!prev_vs && seen_frame) begin
        gap_q.push_back(cur_gap);
      end
      if (frame_done) begin
        n_done++;
        done_cnt_q.push_back(int'(frame_cnt));
        acc_q.push_back(n_acc);
        if (per_img_vsync || !prev_vs) n_done_bad++;
      end
      prev_href = per_img_href;
      prev_vs   = per_img_vsync;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_vs_hi = 0; n_done = 0; n_done_bad = 0; cur_run = 0; cur_hgap = 0; cur_gap = 0;
    prev_href = per_img_href; prev_vs = per_img_vsync; seen_line = 1'b0; seen_frame = 1'b0;
    run_q.delete(); hgap_q.delete(); gap_q.delete(); gray_q.delete();
    done_cnt_q.delete(); acc_q.delete();
    pix = 0; slot_cnt = 0; n_acc = 0; drop_en = 1'b0;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_en();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (n_done < n && k < budget) begin
      tick();
      k++;
    end
    if (n_done < n) check("timeout_frame_done", n_done, n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (frame_busy && k < budget) begin
      tick();
      k++;
    end
    if (frame_busy) check("timeout_idle", frame_busy, 0);
  endtask

  initial begin
    en    = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rst_vsync", per_img_vsync, 0);
    check("rst_href", per_img_href, 0);
    check("rst_gray", per_img_gray, 0);
    check("rst_ready", s_ready, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    tick();

    // Single frame with en pulsed.
    clear_stats();
    pulse_en();
    check("t1_busy_rise", frame_busy, 1);
    check("t1_vsync_lag", per_img_vsync, 0);
    tick();
    check("t1_vsync_rise", per_img_vsync, 1);
    wait_done(1, 200);
    check("t1_vsync_len", n_vs_hi, 56);
    check("t1_lines", run_q.size(), 4);
    for (int i = 0; i < run_q.size(); i++) check("t1_line_len", run_q[i], 8);
    check("t1_hgaps", hgap_q.size(), 3);
    for (int i = 0; i < hgap_q.size(); i++) check("t1_hblank", hgap_q[i], 4);
    check("t1_pixels", gray_q.size(), 32);
    for (int i = 0; i < gray_q.size(); i++) check("t1_gray", gray_q[i], i);
    check("t1_done_align", n_done_bad, 0);
    check("t1_cnt", frame_cnt, 1);
    check("t1_underrun", underrun, 0);
    repeat (4) tick();
    check("t1_idle", frame_busy, 0);
    check("t1_ndone", n_done, 1);

    // Three back-to-back frames with en held.
    do_reset();
    clear_stats();
    en = 1'b1;
    wait_done(3, 400);
    check("t2_cnt1", done_cnt_q[0], 1);
    check("t2_cnt2", done_cnt_q[1], 2);
    check("t2_cnt3", done_cnt_q[2], 3);
    check("t2_accepted", acc_q[2], 96);
    check("t2_ngaps", gap_q.size() >= 2, 1);
    check("t2_gap1", gap_q[0], 2);
    check("t2_gap2", gap_q[1], 2);
    check("t2_done_align", n_done_bad, 0);
    en = 1'b0;
    wait_idle(200);

    // Underrun on the 5th slot of the second line.
    do_reset();
    clear_stats();
    drop_en  = 1'b1;
    drop_idx = 12;
    pulse_en();
    wait_done(1, 200);
    check("t3_pixels", gray_q.size(), 32);
    check("t3_gray_before", gray_q[11], 11);
    check("t3_gray_hole", gray_q[12], 0);
    check("t3_gray_after", gray_q[13], 12);
    check("t3_line2_len", run_q[1], 8);
    check("t3_lines", run_q.size(), 4);
    check("t3_underrun", underrun, 1);
    wait_idle(20);
    clear_stats();
    pulse_en();
    wait_done(1, 200);
    check("t3_sticky", underrun, 1);
    check("t3_cnt", frame_cnt, 2);
    wait_idle(20);

    // en dropped during the first line.
    do_reset();
    clear_stats();
    en = 1'b1;
    for (int k = 0; k < 50 && !per_img_href; k++) tick();
    check("t4_href_seen", per_img_href, 1);
    en = 1'b0;
    wait_idle(200);
    check("t4_ndone", n_done, 1);
    check("t4_pixels", gray_q.size(), 32);
    check("t4_busy", frame_busy, 0);
    repeat (20) tick();
    check("t4_no_vsync", n_vs_hi, 56);
    check("t4_still_one", n_done, 1);

    // Reset in the middle of the third line.
    clear_stats();
    pulse_en();
    for (int k = 0; k < 200 && !(run_q.size() >= 2 && per_img_href); k++) tick();
    check("t5_in_line3", run_q.size() == 2 && per_img_href, 1);
    rst_n = 1'b0;
    #1;
    check("t5_vsync", per_img_vsync, 0);
    check("t5_href", per_img_href, 0);
    check("t5_gray", per_img_gray, 0);
    check("t5_ready", s_ready, 0);
    check("t5_busy", frame_busy, 0);
    check("t5_cnt", frame_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_cnt_after", frame_cnt, 0);
    check("t5_no_done", n_done, 0);
    clear_stats();
    pulse_en();
    wait_done(1, 200);
    check("t5_full_frame", n_vs_hi, 56);
    check("t5_cnt_new", frame_cnt, 1);
    wait_idle(20);

    // frame_cnt wrap.
    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    tick();
    check("t6_preload", frame_cnt, 32'h0000FFFF);
    clear_stats();
    pulse_en();
    wait_done(1, 200);
    check("t6_wrap_at_done", done_cnt_q[0], 0);
    check("t6_wrap", frame_cnt, 0);
    wait_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
